// File: rtl/my_xor.sv
// rtl/my_xor.sv - bitwise XOR cell with combinational and registered outputs
//
// Purpose: y = a ^ b continuously; y_q captures a ^ b on clk edges where
//          in_valid is high, with out_valid flagging a fresh capture.
// Optional feature macro: MY_XOR_PARITY_EN adds a registered parity output.
// Ports:
//   clk       in   1      rising-edge clock (registered path only)
//   rst_n     in   1      asynchronous active-low reset
//   a, b      in   WIDTH  operands
//   in_valid  in   1      qualifies a/b for capture
//   y         out  WIDTH  a ^ b, combinational
//   y_q       out  WIDTH  registered a ^ b
//   parity    out  1      ^(a ^ b), registered (MY_XOR_PARITY_EN only)
//   out_valid out  1      y_q was captured on the previous edge
module my_xor #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
`ifdef MY_XOR_PARITY_EN
    output logic             parity,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] y_d;
    logic             out_valid_d;
    logic             out_valid_q;

    // Pure logic path: no clock or reset dependence, X propagates naturally.
    assign y = a ^ b;

    always_comb begin
        y_d         = y_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            y_d = y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= RESET_VAL;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

`ifdef MY_XOR_PARITY_EN
    logic parity_d;
    logic parity_q;

    // Parity holds alongside y_q when no capture occurs.
    always_comb begin
        parity_d = parity_q;
        if (in_valid) begin
            parity_d = ^y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_my_xor.sv
// tb/tb_my_xor.sv - scoreboard testbench for my_xor (WIDTH=8 and WIDTH=1 instances)
`timescale 1ns/1ps
module tb_my_xor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       v8 = 1'b0;
    logic [7:0] y8, yq8;
    logic       ov8;
    logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
    logic       y1, yq1, ov1;
`ifdef MY_XOR_PARITY_EN
    logic       par8, par1;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       v;
        logic [7:0] y;
        logic       p;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] held_y = 8'h00;
    logic       held_p = 1'b0;

    always #5 clk = ~clk;

    my_xor #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8),
        .y(y8), .y_q(yq8),
`ifdef MY_XOR_PARITY_EN
        .parity(par8),
`endif
        .out_valid(ov8)
    );

    my_xor #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
        .y(y1), .y_q(yq1),
`ifdef MY_XOR_PARITY_EN
        .parity(par1),
`endif
        .out_valid(ov1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: XOR is "bits that differ"; parity is odd count of them.
    function automatic logic [7:0] ref_xor(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (x[i] != z[i]);
        return r;
    endfunction

    function automatic logic ref_par(input logic [7:0] x, input logic [7:0] z);
        return ($countones(ref_xor(x, z)) % 2) == 1;
    endfunction

    // One stimulus cycle: drive after negedge, check comb y, record expectation at the edge.
    task automatic cycle(input logic [7:0] xa, input logic [7:0] xb, input logic xv);
        exp_t e;
        @(negedge clk);
        a8 = xa; b8 = xb; v8 = xv;
        #1 check("y_comb", y8, ref_xor(xa, xb));
        @(posedge clk);
        if (xv) begin
            held_y = ref_xor(xa, xb);
            held_p = ref_par(xa, xb);
        end
        e.v = xv; e.y = held_y; e.p = held_p;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: registered outputs compared against the queued expectation every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_valid", ov8, e.v);
            check("y_q", yq8, e.y);
`ifdef MY_XOR_PARITY_EN
            check("parity", par8, e.p);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] tv;
        // Reset held, no clock edges needed: truth table on both widths.
        for (int i = 0; i < 4; i++) begin
            tv = i[1:0];
            a1 = tv[1]; b1 = tv[0];
            a8 = {8{tv[1]}}; b8 = {8{tv[0]}};
            #1;
            check("y1_truth", y1, (tv == 2'b01 || tv == 2'b10) ? 1 : 0);
            check("y8_in_reset", y8, ref_xor(a8, b8));
            check("yq_in_reset", yq8, 8'h00);
            check("ov_in_reset", ov8, 0);
            check("yq1_in_reset", yq1, 0);
            check("ov1_in_reset", ov1, 0);
`ifdef MY_XOR_PARITY_EN
            check("par_in_reset", par8, 0);
`endif
            #1;
        end
        @(negedge clk);
        rst_n = 1'b1;

        cycle(8'hF0, 8'h3C, 1'b1);
        cycle(8'hAA, 8'h55, 1'b1);
        for (int i = 0; i < 3; i++) cycle(8'($urandom), 8'($urandom), 1'b0);
        cycle(8'h07, 8'h00, 1'b1);
        cycle(8'h03, 8'h00, 1'b1);
        cycle(8'hAA, 8'h55, 1'b1);
        drain();

        // Asynchronous reset between edges while y_q = FF.
        @(posedge clk);
        #2 rst_n = 1'b0;
        a8 = 8'h5A; b8 = 8'h0F;
        #1;
        check("async_rst_yq", yq8, 8'h00);
        check("async_rst_ov", ov8, 0);
        check("async_rst_y", y8, 8'h55);
`ifdef MY_XOR_PARITY_EN
        check("async_rst_par", par8, 0);
`endif
        v8 = 1'b0;
        held_y = 8'h00; held_p = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++)
            cycle(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
